// File: rtl/pattern_pkg.sv
// Shared types and helpers for the single-character matcher.
package pattern_pkg;

  localparam int CHAR_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when the byte is an ASCII letter, A-Z or a-z.
  function automatic logic is_alpha(input logic [CHAR_W-1:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/pattern_bit_cmp.sv
// One-bit masked compare: flags a mismatch only for cared-about bits
// that are not being ignored for case folding.
module pattern_bit_cmp (
  input  logic data_bit,
  input  logic pattern_bit,
  input  logic mask_bit,
  input  logic ignore_bit,
  output logic mismatch
);

  assign mismatch = mask_bit & ~ignore_bit & (data_bit ^ pattern_bit);

endmodule

// File: rtl/pattern.sv
// Single-character matcher. Captures one byte after reset, compares it
// MSB first against PATTERN under MASK, then holds rdy/y until reset.
// Optional feature macro: PATTERN_NOCASE_EN (case-insensitive letters).
module pattern
  import pattern_pkg::*;
#(
  parameter logic [CHAR_W-1:0] PATTERN = 8'h61,
  parameter logic [CHAR_W-1:0] MASK    = 8'hFF,
  parameter bit                INVERT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] x,
  output logic              rdy,
  output logic              y
);

  state_e             state_q, state_d;
  logic [CHAR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mismatch_q, mismatch_d;
  logic               rdy_q, rdy_d;
  logic               y_q, y_d;
  logic               ignore_bit;
  logic               bit_mismatch;
  logic               scan_mismatch;
  logic               last_bit;

`ifdef PATTERN_NOCASE_EN
  logic               nocase_q, nocase_d;

  // Bit 5 is the ASCII case bit; skip it only when both sides are letters.
  assign ignore_bit = nocase_q && (cnt_q == CNT_W'(5));
`else
  assign ignore_bit = 1'b0;
`endif

  assign last_bit      = (cnt_q == '0);
  assign scan_mismatch = mismatch_q | bit_mismatch;

  pattern_bit_cmp u_bit_cmp (
    .data_bit    (sr_q[CHAR_W-1]),
    .pattern_bit (PATTERN[cnt_q]),
    .mask_bit    (MASK[cnt_q]),
    .ignore_bit  (ignore_bit),
    .mismatch    (bit_mismatch)
  );

  // State register; reset always returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: one capture cycle, eight compare cycles, then park in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = SCAN;
      SCAN:    if (last_bit) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result values for the next edge, per state.
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    rdy_d      = rdy_q;
    y_d        = y_q;
`ifdef PATTERN_NOCASE_EN
    nocase_d   = nocase_q;
`endif
    case (state_q)
      IDLE: begin
        sr_d       = x;
        cnt_d      = CNT_W'(CHAR_W - 1);
        mismatch_d = 1'b0;
        rdy_d      = 1'b0;
        y_d        = 1'b0;
`ifdef PATTERN_NOCASE_EN
        nocase_d   = is_alpha(x) && is_alpha(PATTERN);
`endif
      end
      SCAN: begin
        sr_d       = {sr_q[CHAR_W-2:0], 1'b0};
        mismatch_d = scan_mismatch;
        if (last_bit) begin
          rdy_d = 1'b1;
          y_d   = ~scan_mismatch ^ INVERT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      cnt_q      <= CNT_W'(CHAR_W - 1);
      mismatch_q <= 1'b0;
      rdy_q      <= 1'b0;
      y_q        <= 1'b0;
`ifdef PATTERN_NOCASE_EN
      nocase_q   <= 1'b0;
`endif
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      rdy_q      <= rdy_d;
      y_q        <= y_d;
`ifdef PATTERN_NOCASE_EN
      nocase_q   <= nocase_d;
`endif
    end
  end

  assign rdy = rdy_q;
  assign y   = y_q;

endmodule

// File: tb/tb_pattern.sv
// Bench for pattern: five differently configured instances share clk,
// reset and x; a byte-level model predicts rdy/y for every one of them.
module tb_pattern;

  localparam int N = 5;
  localparam logic [7:0] PAT [N] = '{8'h61, 8'h30, 8'h61, 8'h7B, 8'h61};
  localparam logic [7:0] MSK [N] = '{8'hFF, 8'hF0, 8'hFF, 8'hFF, 8'h00};
  localparam bit         INV [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x;
  logic [N-1:0] rdyV, yV;

  int checks   = 0;
  int failures = 0;
  int edgeCnt  = 0;
  logic [7:0] capX = 8'h00;
  bit checkEn = 1'b0;

  pattern u_def (.clk(clk), .reset(reset), .x(x), .rdy(rdyV[0]), .y(yV[0]));
  pattern #(.PATTERN(8'h30), .MASK(8'hF0)) u_mask
    (.clk(clk), .reset(reset), .x(x), .rdy(rdyV[1]), .y(yV[1]));
  pattern #(.INVERT(1'b1)) u_inv
    (.clk(clk), .reset(reset), .x(x), .rdy(rdyV[2]), .y(yV[2]));
  pattern #(.PATTERN(8'h7B)) u_brace
    (.clk(clk), .reset(reset), .x(x), .rdy(rdyV[3]), .y(yV[3]));
  pattern #(.MASK(8'h00)) u_any
    (.clk(clk), .reset(reset), .x(x), .rdy(rdyV[4]), .y(yV[4]));

  always #5 clk = ~clk;

  function automatic bit isLetter(input logic [7:0] c);
    return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
  endfunction

  // Whole-byte reference: masked equality, optional case folding, inversion.
  function automatic logic modelY(input logic [7:0] c, input logic [7:0] p,
                                  input logic [7:0] m, input bit inv);
    logic [7:0] care;
    care = m;
`ifdef PATTERN_NOCASE_EN
    if (isLetter(c) && isLetter(p)) care[5] = 1'b0;
`endif
    return ((((c ^ p) & care) == 8'h00) ? 1'b1 : 1'b0) ^ inv;
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Model timeline: edges since reset release; the first one captures x.
  always @(posedge clk) begin
    if (reset) edgeCnt = 0;
    else begin
      if (edgeCnt == 0) capX = x;
      if (edgeCnt < 1000) edgeCnt++;
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    logic expRdy, expY;
    if (checkEn) begin
      for (int k = 0; k < N; k++) begin
        expRdy = (edgeCnt >= 9);
        expY   = expRdy ? modelY(capX, PAT[k], MSK[k], INV[k]) : 1'b0;
        checkOutput($sformatf("model rdy[%0d]", k), rdyV[k], expRdy);
        checkOutput($sformatf("model y[%0d]", k), yV[k], expY);
      end
    end
  end

  // Reset two cycles, release with xv, swap x to lateX after capture,
  // and return on the negedge after the 9th released edge.
  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] lateX);
    @(negedge clk);
    reset = 1'b1;
    x     = xv;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    x = lateX;
    repeat (7) @(negedge clk);
    checkOutput("rdy low before 9th edge", rdyV[0], 1'b0);
    @(negedge clk);
  endtask

  task automatic runRandom();
    logic [7:0] xv;
    bit doAbort;
    int abortEdge;
    xv = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 2) == 0) xv = 8'h41 + 8'($urandom_range(0, 25)) + ($urandom_range(0, 1) != 0 ? 8'h20 : 8'h00);
    doAbort   = ($urandom_range(0, 3) == 0);
    abortEdge = $urandom_range(1, 10);
    @(negedge clk);
    reset = 1'b1;
    x     = xv;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      @(negedge clk);
      if (doAbort && e == abortEdge) reset = 1'b1;
      else begin
        reset = 1'b0;
        x = 8'($urandom_range(0, 255));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    x     = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset rdy", rdyV[0], 1'b0);
    checkOutput("reset y", yV[0], 1'b0);
    checkEn = 1'b1;

    applyStimulus(8'h61, 8'h61);
    checkOutput("a: rdy", rdyV[0], 1'b1);
    checkOutput("a: y default", yV[0], 1'b1);
    checkOutput("a: y invert", yV[2], 1'b0);
    checkOutput("a: y mask F0", yV[1], 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("a: rdy held", rdyV[0], 1'b1);
    checkOutput("a: y held", yV[0], 1'b1);

    applyStimulus(8'h62, 8'h61);
    checkOutput("b after late a: y", yV[0], 1'b0);
    checkOutput("b: y invert", yV[2], 1'b1);
    checkOutput("b: y mask 00", yV[4], 1'b1);

    applyStimulus(8'h39, 8'h00);
    checkOutput("0x39 mask F0: y", yV[1], 1'b1);
    applyStimulus(8'h49, 8'h39);
    checkOutput("0x49 mask F0: y", yV[1], 1'b0);
    applyStimulus(8'h7A, 8'h61);
    checkOutput("z invert: y", yV[2], 1'b1);
    checkOutput("z default: y", yV[0], 1'b0);

    applyStimulus(8'h41, 8'h00);
`ifdef PATTERN_NOCASE_EN
    checkOutput("A nocase: y", yV[0], 1'b1);
`else
    checkOutput("A exact: y", yV[0], 1'b0);
`endif
    applyStimulus(8'h5B, 8'h7B);
    checkOutput("0x5B vs 0x7B: y", yV[3], 1'b0);
    applyStimulus(8'h7B, 8'h00);
    checkOutput("0x7B vs 0x7B: y", yV[3], 1'b1);

    // Abort on the 5th compare edge, then a fresh full run.
    @(negedge clk);
    reset = 1'b1;
    x = 8'h61;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort: rdy", rdyV[0], 1'b0);
    checkOutput("abort: y", yV[0], 1'b0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("restart: rdy early", rdyV[0], 1'b0);
    @(negedge clk);
    checkOutput("restart: rdy", rdyV[0], 1'b1);
    checkOutput("restart: y", yV[0], 1'b1);

    for (int i = 0; i < 40; i++) runRandom();

    @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
